// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bus bridge: enable encodings,
// FSM state type, default parameters and a byte-lane helper.
package dmem_bridge_pkg;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;

  localparam int          DEFAULT_TIMEOUT   = 16;
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } bridge_state_e;

  // Unselected byte lanes are driven as zero so the bus never sees stale bytes.
  function automatic logic [31:0] mask_lanes(input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] masked;
    masked = '0;
    for (int lane = 0; lane < 4; lane++) begin
      if (sel[lane]) masked[8*lane +: 8] = data[8*lane +: 8];
    end
    return masked;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// External data-bus bundle: the bridge drives it as master, memory answers as slave.
interface dmem_bridge_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/dmem_timeout_ctr.sv
// Loadable down-counter for the bus watchdog; tc is high when the count is zero.
module dmem_timeout_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage to data-bus bridge: registers the request, stalls the pipeline
// until ack or watchdog timeout, then hands the read word back for one cycle.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int          TIMEOUT   = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_ce_i,
  input  logic          mem_we_i,
  input  logic [31:0]   mem_addr_i,
  input  logic [3:0]    mem_sel_i,
  input  logic [31:0]   mem_data_i,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic [31:0]   mem_data_o,
  output logic          stallreq_o,
  dmem_bridge_if.master bus
);

  localparam int CTR_WIDTH = $clog2(TIMEOUT);

  bridge_state_e state_q, state_d;

  logic        accept;
  logic        acked;
  logic        timed_out;
  logic        ctr_tc;
  logic        ctr_load;
  logic        addr_offset_unused;

  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_sel_q;
  logic [31:0] bus_wdata_q;
  logic        bus_err_q;
  logic [31:0] rdata_q;

  assign accept    = (state_q == ST_IDLE) && (mem_ce_i == CHIP_ENABLE) && !flush_i;
  assign acked     = (state_q == ST_REQ) && bus.bus_ack;
  assign timed_out = (state_q == ST_REQ) && !bus.bus_ack && ctr_tc;
  assign ctr_load  = accept || acked;

  assign addr_offset_unused = ^mem_addr_i[1:0];

  // Counter is loaded with TIMEOUT-1 so it hits zero on the TIMEOUT-th REQ cycle.
  dmem_timeout_ctr #(
    .WIDTH (CTR_WIDTH)
  ) u_timeout_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ctr_load),
    .load_value (accept ? CTR_WIDTH'(TIMEOUT - 1) : '0),
    .enable     (state_q == ST_REQ),
    .tc         (ctr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Flush only matters in IDLE and DONE; an issued bus cycle always runs to completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)              state_d = ST_REQ;
      ST_REQ:  if (acked || timed_out)  state_d = ST_DONE;
      ST_DONE: if (flush_i || !stall_i) state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
    end else if (accept) begin
      bus_we_q    <= mem_we_i;
      bus_addr_q  <= {mem_addr_i[31:2], 2'b00};
      bus_sel_q   <= mem_sel_i;
      bus_wdata_q <= mask_lanes(mem_data_i, mem_sel_i);
    end
  end

  // Stores return zero to the pipeline; a timeout substitutes ERR_RDATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timed_out;
      if (acked)          rdata_q <= (bus_we_q == WRITE_ENABLE) ? '0 : bus.bus_rdata;
      else if (timed_out) rdata_q <= ERR_RDATA;
    end
  end

  assign stallreq_o    = accept || (state_q == ST_REQ);
  assign mem_data_o    = rdata_q;

  assign bus.bus_req   = (state_q == ST_REQ);
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_sel   = bus_sel_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed and randomized bench for dmem_bridge with a transaction-level expectation model.
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  localparam int          TIMEOUT  = 4;
  localparam logic [31:0] ERR_WORD = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ce_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] mem_data_o;
  logic        stallreq_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_data = '0;

  dmem_bridge_if bus ();

  dmem_bridge #(
    .TIMEOUT   (TIMEOUT),
    .ERR_RDATA (ERR_WORD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_ce_i   (mem_ce_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_sel_i  (mem_sel_i),
    .mem_data_i (mem_data_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .mem_data_o (mem_data_o),
    .stallreq_o (stallreq_o),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected store data: keep a byte when its lane bit is set, arithmetically.
  function automatic logic [31:0] expect_wdata(input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] mask;
    mask = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) mask = mask + (32'd255 << (8 * i));
    return data & mask;
  endfunction

  // One full MEM access: IDLE request cycle, REQ cycles, DONE (+hold), back to IDLE.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] data, input int delay, input logic [31:0] rdata,
                            input int hold, input int flush_at);
    bit          to;
    int          req_cycles;
    logic [31:0] exp_word;
    to         = (delay > TIMEOUT);
    req_cycles = to ? TIMEOUT : delay;
    exp_word   = to ? ERR_WORD : (we ? 32'h0 : rdata);

    mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
    flush_i = 1'b0; stall_i = 1'b0; bus.bus_ack = 1'b0;
    #1;
    check("idle_stallreq", stallreq_o, 1'b1);
    check("idle_no_req", bus.bus_req, 1'b0);
    check("idle_data_hold", mem_data_o, last_data);

    for (int k = 1; k <= req_cycles; k++) begin
      next_cycle();
      flush_i       = (k == flush_at);
      bus.bus_ack   = !to && (k == delay);
      bus.bus_rdata = bus.bus_ack ? rdata : $urandom;
      #1;
      check("req_high", bus.bus_req, 1'b1);
      check("req_stallreq", stallreq_o, 1'b1);
      check("req_addr", bus.bus_addr, addr - (addr % 4));
      check("req_sel", {28'h0, bus.bus_sel}, {28'h0, sel});
      check("req_we", bus.bus_we, we);
      check("req_wdata", bus.bus_wdata, expect_wdata(data, sel));
      check("req_no_err", bus.bus_err, 1'b0);
    end

    next_cycle();
    bus.bus_ack = 1'b0; flush_i = 1'b0; stall_i = (hold > 0);
    #1;
    check("done_stallreq", stallreq_o, 1'b0);
    check("done_no_req", bus.bus_req, 1'b0);
    check("done_err", bus.bus_err, to);
    check("done_data", mem_data_o, exp_word);

    for (int h = 1; h <= hold; h++) begin
      next_cycle();
      stall_i       = (h < hold);
      bus.bus_ack   = $urandom_range(0, 1);
      bus.bus_rdata = $urandom;
      #1;
      check("hold_no_req", bus.bus_req, 1'b0);
      check("hold_stallreq", stallreq_o, 1'b0);
      check("hold_data", mem_data_o, exp_word);
      check("hold_no_err", bus.bus_err, 1'b0);
    end

    next_cycle();
    mem_ce_i = 1'b0; bus.bus_ack = 1'b0; stall_i = 1'b0;
    #1;
    check("back_idle_no_req", bus.bus_req, 1'b0);
    check("back_idle_stallreq", stallreq_o, 1'b0);
    check("back_idle_data", mem_data_o, exp_word);
    check("back_idle_no_err", bus.bus_err, 1'b0);
    last_data = exp_word;
  endtask

  initial begin
    bit          r_we;
    logic [31:0] r_addr, r_data, r_rdata;
    logic [3:0]  r_sel;
    int          r_delay, r_hold, r_flush;

    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;
    #12;
    check("rst_req", bus.bus_req, 1'b0);
    check("rst_we", bus.bus_we, 1'b0);
    check("rst_err", bus.bus_err, 1'b0);
    check("rst_addr", bus.bus_addr, 32'h0);
    check("rst_wdata", bus.bus_wdata, 32'h0);
    check("rst_sel", {28'h0, bus.bus_sel}, 32'h0);
    check("rst_mem_data", mem_data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_access(1'b0, 32'h0000_0104, 4'b1111, 32'h0, 3, 32'hCAFE_F00D, 0, 0);
    run_access(1'b1, 32'h0000_0012, 4'b0011, 32'h1234_5678, 1, 32'hFFFF_FFFF, 0, 0);
    run_access(1'b0, 32'h0000_0033, 4'b0000, 32'hABCD_EF01, 2, 32'h55AA_1234, 0, 0);
    run_access(1'b0, 32'h0000_0200, 4'b1111, 32'h0, TIMEOUT + 3, 32'h0, 0, 0);
    run_access(1'b0, 32'h0000_0300, 4'b1100, 32'h0, 2, 32'h7654_3210, 3, 0);
    run_access(1'b0, 32'h0000_0404, 4'b1111, 32'h0, 2, 32'h0F0F_F0F0, 0, 1);

    // Flush in IDLE with a pending request must not issue anything.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h500; flush_i = 1'b1;
    #1;
    check("idle_flush_stallreq", stallreq_o, 1'b0);
    next_cycle();
    flush_i = 1'b0; mem_ce_i = 1'b0;
    #1;
    check("idle_flush_no_req", bus.bus_req, 1'b0);

    // Ack while IDLE is ignored.
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hDEAD_BEEF;
    next_cycle();
    bus.bus_ack = 1'b0;
    #1;
    check("stray_ack_data", mem_data_o, last_data);
    check("stray_ack_no_req", bus.bus_req, 1'b0);

    // Flush in DONE leaves even while stalled; the next request is accepted at once.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h40; mem_sel_i = 4'hF;
    next_cycle();
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h0BAD_CAFE;
    #1;
    check("fd_req", bus.bus_req, 1'b1);
    next_cycle();
    bus.bus_ack = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
    #1;
    check("fd_done_data", mem_data_o, 32'h0BAD_CAFE);
    check("fd_done_stallreq", stallreq_o, 1'b0);
    next_cycle();
    stall_i = 1'b0; flush_i = 1'b0; mem_addr_i = 32'h80;
    #1;
    check("fd_idle_accept", stallreq_o, 1'b1);
    next_cycle();
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h1111_2222;
    #1;
    check("fd_new_req", bus.bus_req, 1'b1);
    check("fd_new_addr", bus.bus_addr, 32'h80);
    next_cycle();
    bus.bus_ack = 1'b0;
    #1;
    check("fd_new_data", mem_data_o, 32'h1111_2222);
    next_cycle();
    mem_ce_i = 1'b0;
    #1;
    check("fd_idle_no_req", bus.bus_req, 1'b0);
    last_data = 32'h1111_2222;

    // Reset in the middle of a store clears every output immediately.
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0208; mem_sel_i = 4'hF;
    mem_data_i = 32'hA5A5_A5A5;
    next_cycle();
    check("mid_rst_req_before", bus.bus_req, 1'b1);
    rst_n = 1'b0; mem_ce_i = 1'b0;
    #1;
    check("mid_rst_req", bus.bus_req, 1'b0);
    check("mid_rst_we", bus.bus_we, 1'b0);
    check("mid_rst_addr", bus.bus_addr, 32'h0);
    check("mid_rst_sel", {28'h0, bus.bus_sel}, 32'h0);
    check("mid_rst_wdata", bus.bus_wdata, 32'h0);
    check("mid_rst_data", mem_data_o, 32'h0);
    check("mid_rst_stallreq", stallreq_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    last_data = 32'h0;
    run_access(1'b0, 32'h0000_0608, 4'b0110, 32'h0, 2, 32'h3C3C_5A5A, 0, 0);

    for (int t = 0; t < 24; t++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = $urandom;
      r_sel   = 4'($urandom_range(0, 15));
      r_data  = $urandom;
      r_rdata = $urandom;
      r_delay = $urandom_range(1, TIMEOUT + 2);
      r_hold  = $urandom_range(0, 2);
      r_flush = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (r_delay > TIMEOUT) ? TIMEOUT : r_delay) : 0;
      run_access(r_we, r_addr, r_sel, r_data, r_delay, r_rdata, r_hold, r_flush);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bus bridge sitting directly downstream of the MEM stage. It accepts the stage's combinational memory request (chip enable, write enable, address, byte select, write data) and runs it as a registered request/acknowledge transaction on the external data bus. While the access is outstanding it holds the pipeline through a stall request, then returns read data to the MEM stage for one released cycle. A timeout watchdog aborts accesses that never receive an acknowledge.

## Interface
Parameters:
- TIMEOUT, 16: cycles in REQ without `bus_ack_i` before abort (≥2).
- ERR_RDATA, 32'h00000000: read data returned on timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_ce_i  in  1  request valid from the MEM stage.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  32  byte address.
- mem_sel_i  in  4  byte lanes; bit 3 = data[31:24].
- mem_data_i  in  32  store data.
- stall_i  in  1  pipeline held by another source this cycle.
- flush_i  in  1  pipeline flush.
- mem_data_o  out  32  load data to the MEM stage.
- stallreq_o  out  1  stall request to pipeline control.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  32  word-aligned bus address.
- bus_sel_o  out  4  bus byte enables.
- bus_wdata_o  out  32  bus write data.
- bus_ack_i  in  1  bus acknowledge; single-cycle pulse.
- bus_rdata_i  in  32  bus read data; valid when `bus_ack_i` = 1.
- bus_err_o  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, REQ, DONE.
- IDLE:
  - If `mem_ce_i` = 1 and `flush_i` = 0: latch the request into bus registers and go to REQ.
    - `bus_addr_o` = {addr[31:2], 2'b00}.
    - `bus_sel_o` = `mem_sel_i`.
    - `bus_we_o` = `mem_we_i`.
    - `bus_wdata_o` = `mem_data_i` with unselected byte lanes forced to 0.
  - `mem_sel_i` = 0 with `mem_ce_i` = 1 is still issued.
- REQ:
  - `bus_req_o` = 1 and all bus outputs stay stable.
  - On `bus_ack_i`: capture `bus_rdata_i` (writes capture 0), clear the timeout counter, go to DONE.
  - If the counter reaches TIMEOUT first: capture ERR_RDATA, pulse `bus_err_o`, go to DONE.
  - `flush_i` is ignored in REQ; the transaction always completes.
- DONE:
  - `mem_data_o` presents the captured word and `stallreq_o` = 0.
  - If `stall_i` = 1, stay in DONE and hold the data. The MEM request is still on the inputs and must not be re-issued.
  - Else go to IDLE.
  - `flush_i` in DONE goes to IDLE unconditionally.
- `stallreq_o` = (IDLE & `mem_ce_i` & ~`flush_i`) | REQ. It is combinational so the request cycle itself stalls.
- `mem_data_o` holds its last captured value outside DONE.
- `bus_ack_i` outside REQ is ignored.

## Timing
- Reset (async assert, sync deassert assumed upstream):
  - State IDLE; `bus_req_o`, `bus_we_o`, `bus_err_o` = 0.
  - `bus_addr_o`, `bus_wdata_o`, `mem_data_o` = 0.
  - `bus_sel_o` = 4'b0000; timeout counter = 0.
- Reset in REQ drops `bus_req_o` immediately and abandons the transaction.
- Request seen in cycle N (IDLE). `bus_req_o` is high from cycle N+1. Ack sampled at the end of cycle M ≥ N+1. DONE in M+1.
- Minimum stall: 2 cycles (N, N+1); release cycle N+2.
- Timeout: `bus_err_o` high in the cycle after the TIMEOUT-th REQ cycle, coincident with DONE entry.
- Back-to-back: new request accepted no earlier than one cycle after DONE exits.

## Structure
- State encodings and ERR_RDATA default go in the shared defines file next to ChipEnable/WriteEnable.
- One natural sub-module: `dmem_timeout_ctr`, a loadable down-counter with a terminal-count output.
- Otherwise flat: one state register, one bus-register bank, one read-data register.

## Test plan
- Word load: ce=1, we=0, addr=0x00000104, sel=1111, ack after 3 cycles with rdata=0xCAFEF00D.
  - bus_addr=0x00000104 and bus_req is high for 3 cycles.
  - stallreq is high for 4 cycles; mem_data_o=0xCAFEF00D in the DONE cycle.
- Halfword store: addr=0x00000012, sel=0011, data=0x12345678, ack immediately.
  - bus_addr=0x00000010, bus_wdata=0x00005678, bus_we=1, 2-cycle stall.
- Timeout with TIMEOUT=4 and no ack.
  - bus_err pulses once; mem_data_o=0x00000000; state returns to IDLE; bus_req drops.
- Hold in DONE: stall_i=1 for 3 cycles after ack, inputs unchanged.
  - No second bus_req; mem_data_o is stable throughout.
- Flush during REQ, then ack.
  - Transaction completes; DONE then IDLE; no re-issue.
- rst_n low mid-REQ: bus_req and all outputs go to 0 asynchronously; the next request after release is issued normally.
